// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory slice.
//   - load/store func3 encodings (F3_*)
//   - access FSM states
//   - latched request record
package dmem_pkg;

    localparam int NUM_LANES = 4;   // byte lanes per 32-bit word

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr;    // store (wins over load when both requested)
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the data memory.
//   func3    in   access size/sign
//   addr_lo  in   byte offset within the word
//   st_data  in   raw store data from the pipeline
//   ld_word  in   aligned 32-bit word read from storage
//   be       out  per-lane write enable
//   wdata    out  store data replicated onto every lane
//   ld_data  out  selected and extended load result
// Alignment is forced: halves ignore addr_lo[0], words ignore addr_lo.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [2:0]           func3,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          st_data,
    input  logic [31:0]          ld_word,
    output logic [NUM_LANES-1:0] be,
    output logic [31:0]          wdata,
    output logic [31:0]          ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    // Store lanes: anything other than B/H is a full word store.
    always_comb begin
        be    = 4'hF;
        wdata = st_data;
        case (func3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lanes: unlisted encodings fall back to a full word.
    always_comb begin
        ld_data = ld_word;
        case (func3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: fixed-latency byte-addressed data memory for the RV32IM MEM stage.
//   CLK             in   clock
//   RESET           in   synchronous, active-low reset
//   MEM_READ        in   load request
//   MEM_WRITE       in   store request
//   FUNC3           in   access size/sign
//   MEM_ADDRESS     in   byte address (wraps at 2^ADDR_WIDTH)
//   MEM_WRITE_DATA  in   store data
//   READ_DATA       out  registered load result
//   BUSYWAIT        out  pipeline stall, high for LATENCY cycles per access
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    req_t                  req_q, cur_req, acc;
    logic                  req, latch, do_acc;
    logic [NUM_LANES-1:0]  be;
    logic [31:0]           wdata, ld_word, ld_data;
    logic [ADDR_WIDTH-3:0] widx;
    logic                  addr_unused;

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    assign req     = RESET && (MEM_READ || MEM_WRITE);
    assign cur_req = '{wr: MEM_WRITE, f3: FUNC3, addr: MEM_ADDRESS, data: MEM_WRITE_DATA};

    // With LATENCY=1 the access happens on the request edge, so the live
    // request must be steered to storage instead of the (not yet loaded) latch.
    assign acc         = (state == IDLE) ? cur_req : req_q;
    assign widx        = acc.addr[ADDR_WIDTH-1:2];
    assign addr_unused = ^acc.addr[31:ADDR_WIDTH];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        BUSYWAIT = 1'b0;
        latch    = 1'b0;
        do_acc   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    BUSYWAIT = 1'b1;
                    latch    = 1'b1;
                    if (LATENCY == 1) begin
                        do_acc   = 1'b1;
                        cnt_nx   = 4'd0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = CNT_INIT;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                BUSYWAIT = 1'b1;
                cnt_nx   = cnt - 4'd1;
                // Counter reaching zero on this edge is the access edge.
                if (cnt <= 4'd1) begin
                    cnt_nx   = 4'd0;
                    do_acc   = 1'b1;
                    state_nx = DONE;
                end
            end
            // Request still visible here belongs to the finished instruction.
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_q     <= '0;
            READ_DATA <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (latch)
                req_q <= cur_req;
            if (do_acc && !acc.wr)
                READ_DATA <= ld_data;
        end
    end

    // Storage is not reset; an aborted store never reaches it because the
    // write is gated by RESET on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET && do_acc && acc.wr) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (be[i])
                    mem[{widx, 2'(i)}] <= wdata[8*i +: 8];
        end
    end

    always_comb begin
        ld_word = '0;
        for (int i = 0; i < NUM_LANES; i++)
            ld_word[8*i +: 8] = mem[{widx, 2'(i)}];
    end

    lsu_align u_align (
        .func3   (acc.f3),
        .addr_lo (acc.addr[1:0]),
        .st_data (acc.data),
        .ld_word (ld_word),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MEM_READ = 1'b0;
    logic        MEM_WRITE = 1'b0;
    logic [2:0]  FUNC3 = 3'b000;
    logic [31:0] MEM_ADDRESS = '0;
    logic [31:0] MEM_WRITE_DATA = '0;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'd0;

    data_memory #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .FUNC3          (FUNC3),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy window followed by a low cycle is a DONE cycle.
    int  run = 0;
    bit  aborted = 0;
    always @(negedge CLK) begin
        if (!RESET) begin
            aborted = 1;
            run = 0;
        end else if (BUSYWAIT === 1'b1) begin
            run++;
        end else begin
            if (run > 0 && !aborted) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got READ_DATA %h with empty scoreboard", READ_DATA);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if (READ_DATA !== e) begin
                        errors++;
                        $display("FAIL done_data: got %h expected %h", READ_DATA, e);
                    end
                    if (run != LAT) begin
                        errors++;
                        $display("FAIL busy_len: got %0d expected %0d", run, LAT);
                    end
                end
            end
            run = 0;
            aborted = 0;
        end
    end

    // Issue one memory instruction and hold it until its DONE cycle ends,
    // as the frozen EX/MEM register would.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd);
        bit seen = 0;
        bit fin  = 0;
        exp_q.push_back(exp_rd);
        last_rd = exp_rd;
        MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3;
        MEM_ADDRESS = addr; MEM_WRITE_DATA = wd;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b1) seen = 1;
            else if (seen) fin = 1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: addr %h no DONE within 40 cycles", addr);
        end
        @(posedge CLK); #1;
        MEM_READ = 0; MEM_WRITE = 0;
    endtask

    initial begin
        int t0;
        // Reset held for two cycles
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        chk("rst_read_data", READ_DATA, 32'd0);
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        chk("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);

        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0);          // SW
        access(1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF);   // LW
        access(0, 1, 3'b000, 32'h11, 32'hAAAAAA80, 32'hDEADBEEF);   // SB keeps READ_DATA
        access(1, 0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80);   // LB
        access(1, 0, 3'b100, 32'h11, 32'h0,        32'h00000080);   // LBU
        access(1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF);   // LW
        access(1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD);   // LH
        access(1, 0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD);   // LHU
        access(1, 0, 3'b010, 32'h13, 32'h0,        32'hDEAD80EF);   // LW misaligned
        access(1, 0, 3'b010, 32'h10 + (32'd1 << AW), 32'h0, 32'hDEAD80EF); // wrap
        access(1, 1, 3'b010, 32'h30, 32'h11223344, 32'hDEAD80EF);   // both: store wins
        access(1, 0, 3'b111, 32'h30, 32'h0,        32'h11223344);   // 111 loads a word
        access(0, 1, 3'b001, 32'h33, 32'hFFFF5566, 32'h11223344);   // SH upper half
        access(1, 0, 3'b010, 32'h30, 32'h0,        32'h55663344);
        access(0, 1, 3'b101, 32'h20, 32'h0BADF00D, 32'h55663344);   // 101 store = SW

        // Back-to-back loads: 2*(LAT+1) cycles, single DONE between windows
        t0 = cyc;
        access(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF);
        access(1, 0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF);
        chk("b2b_cycles", 32'(cyc - t0), 32'(2 * (LAT + 1)));

        // Store aborted by reset in its 2nd BUSY cycle
        MEM_WRITE = 1; FUNC3 = 3'b010; MEM_ADDRESS = 32'h20; MEM_WRITE_DATA = 32'h12345678;
        @(posedge CLK); #1;                 // 1st BUSY cycle
        @(posedge CLK); #1;                 // 2nd BUSY cycle
        chk("abort_busy_before", {31'd0, BUSYWAIT}, 32'd1);
        RESET = 1'b0; MEM_WRITE = 0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        chk("abort_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("abort_read_data", READ_DATA, 32'd0);
        @(posedge CLK); #1;
        chk("abort_idle", {31'd0, BUSYWAIT}, 32'd0);
        access(1, 0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
